// File: rtl/mbf_fir_bank.sv
// Multi-bank direct-form FIR: shared delay line, per-sample coefficient bank select,
// two-stage pipeline (full-precision sum, then round/shift/saturate).
module mbf_fir_bank #(
   parameter int unsigned DW    = 8,
   parameter int unsigned TAPS  = 16,
   parameter int unsigned CW    = 12,
   parameter int unsigned BANKS = 2,
   parameter int unsigned FRAC  = 9,
   localparam int unsigned BW   = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int unsigned IW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   input  logic [BW-1:0]        bank_sel,
   input  logic                 coef_we,
   input  logic [BW-1:0]        coef_bank,
   input  logic [IW-1:0]        coef_idx,
   input  logic signed [CW-1:0] coef_data,
   input  logic                 hist_clr,
   output logic                 out_valid,
   output logic signed [DW-1:0] out_data,
   output logic                 out_sat
);

   localparam int unsigned PW = DW + CW;
   localparam int unsigned AW = DW + CW + IW;

   localparam int MaxI = (1 << (DW - 1)) - 1;
   localparam int MinI = -(1 << (DW - 1));
   localparam logic signed [AW:0]   MaxV  = (AW + 1)'(MaxI);
   localparam logic signed [AW:0]   MinV  = (AW + 1)'(MinI);
   localparam logic signed [DW-1:0] MaxD  = DW'(MaxI);
   localparam logic signed [DW-1:0] MinD  = DW'(MinI);
   localparam logic signed [AW:0]   Round = (AW + 1)'(1 << (FRAC - 1));

   logic signed [CW-1:0] coef_q [BANKS][TAPS];
   logic signed [CW-1:0] coef_d [BANKS][TAPS];
   logic signed [DW-1:0] hist_q [TAPS-1];
   logic signed [DW-1:0] hist_d [TAPS-1];

   logic signed [DW-1:0] taps_x [TAPS];
   logic signed [PW-1:0] prod   [TAPS];
   logic [BW-1:0]        bank_rd;
   logic                 accept;

   logic signed [AW-1:0] acc_q, acc_d;
   logic                 valid1_q;

   logic signed [AW:0]   rnd;
   logic signed [AW:0]   shifted;
   logic signed [DW-1:0] res;
   logic                 sat;

   logic                 out_valid_q;
   logic signed [DW-1:0] out_data_q;
   logic                 out_sat_q;

   // A clear in the same cycle as a sample drops the sample.
   assign accept = in_valid && !hist_clr;

   // Coefficient memory: out-of-range writes are silently dropped.
   always_comb begin
      coef_d = coef_q;
      if (coef_we && (32'(coef_bank) < BANKS) && (32'(coef_idx) < TAPS)) begin
         coef_d[coef_bank][coef_idx] = coef_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < BANKS; b++) begin
            for (int k = 0; k < TAPS; k++) begin
               coef_q[b][k] <= '0;
            end
         end
      end else begin
         coef_q <= coef_d;
      end
   end

   always_comb begin
      hist_d = hist_q;
      if (hist_clr) begin
         for (int k = 0; k < TAPS - 1; k++) begin
            hist_d[k] = '0;
         end
      end else if (in_valid) begin
         hist_d[0] = in_data;
         for (int k = 1; k < TAPS - 1; k++) begin
            hist_d[k] = hist_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < TAPS - 1; k++) begin
            hist_q[k] <= '0;
         end
      end else begin
         hist_q <= hist_d;
      end
   end

   // Stage 1: full-precision dot product of current sample plus history.
   always_comb begin
      bank_rd = (32'(bank_sel) < BANKS) ? bank_sel : '0;
      taps_x[0] = in_data;
      for (int k = 1; k < TAPS; k++) begin
         taps_x[k] = hist_q[k-1];
      end
      acc_d = '0;
      for (int k = 0; k < TAPS; k++) begin
         prod[k] = PW'(coef_q[bank_rd][k]) * PW'(taps_x[k]);
         acc_d   = acc_d + AW'(prod[k]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q    <= '0;
         valid1_q <= 1'b0;
      end else begin
         valid1_q <= accept;
         if (accept) begin
            acc_q <= acc_d;
         end
      end
   end

   // Stage 2: round half up, arithmetic shift, clamp to the output range.
   always_comb begin
      rnd     = (AW + 1)'(acc_q) + Round;
      shifted = rnd >>> FRAC;
      sat     = 1'b0;
      res     = shifted[DW-1:0];
      if (shifted > MaxV) begin
         sat = 1'b1;
         res = MaxD;
      end else if (shifted < MinV) begin
         sat = 1'b1;
         res = MinD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         out_valid_q <= valid1_q;
         if (valid1_q) begin
            out_data_q <= res;
            out_sat_q  <= sat;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mbf_fir_bank.sv
// Directed bench for mbf_fir_bank: rounding, saturation, banks, write timing,
// impulse response, idle gaps, history clear and mid-stream reset.
module tb_mbf_fir_bank;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic signed [7:0] in_data;
   logic [0:0]        bank_sel;
   logic              coef_we;
   logic [0:0]        coef_bank;
   logic [3:0]        coef_idx;
   logic signed [11:0] coef_data;
   logic              hist_clr;
   logic              out_valid;
   logic signed [7:0] out_data;
   logic              out_sat;

   int checks   = 0;
   int failures = 0;

   mbf_fir_bank dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .bank_sel  (bank_sel),
      .coef_we   (coef_we),
      .coef_bank (coef_bank),
      .coef_idx  (coef_idx),
      .coef_data (coef_data),
      .hist_clr  (hist_clr),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input logic b, input logic [3:0] idx, input logic signed [11:0] d);
      coef_we   = 1'b1;
      coef_bank = b;
      coef_idx  = idx;
      coef_data = d;
      cycle();
      coef_we   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) cycle();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'sd0 || out_sat !== 1'b0) begin
         failures++;
         $display("FAIL reset_state valid=%b data=%0d sat=%b, required 0/0/0",
                  out_valid, out_data, out_sat);
      end
      reset = 1'b0;
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_rounding();
      logic signed [7:0] xs [3];
      logic signed [7:0] ex [3];
      xs = '{8'sd3, -8'sd3, 8'sd1};
      ex = '{8'sd2, -8'sd1, 8'sd1};
      write_coef(1'b0, 4'd0, 12'sd256);
      for (int i = 0; i <= 3; i++) begin
         in_valid = (i < 3);
         in_data  = (i < 3) ? xs[i] : 8'sd0;
         bank_sel = 1'b0;
         cycle();
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== ex[i-1] || out_sat !== 1'b0) begin
               failures++;
               $display("FAIL rounding[%0d] valid=%b data=%0d sat=%b, required 1/%0d/0",
                        i - 1, out_valid, out_data, out_sat, ex[i-1]);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_saturation();
      logic signed [7:0] xs [3];
      logic signed [7:0] ex [3];
      logic              es [3];
      xs = '{8'sd127, 8'h80, 8'sd0};
      ex = '{8'sd127, 8'h80, 8'sd0};
      es = '{1'b1, 1'b1, 1'b0};
      write_coef(1'b0, 4'd0, 12'sd2047);
      for (int i = 0; i <= 3; i++) begin
         in_valid = (i < 3);
         in_data  = (i < 3) ? xs[i] : 8'sd0;
         cycle();
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== ex[i-1] || out_sat !== es[i-1]) begin
               failures++;
               $display("FAIL saturation[%0d] valid=%b data=%0d sat=%b, required 1/%0d/%b",
                        i - 1, out_valid, out_data, out_sat, ex[i-1], es[i-1]);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_bank_timing();
      write_coef(1'b1, 4'd0, -12'sd512);
      in_valid = 1'b1; in_data = 8'sd10; bank_sel = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== -8'sd10) begin
         failures++;
         $display("FAIL bank1_neg valid=%b data=%0d, required 1/-10", out_valid, out_data);
      end
      // Write and sample in the same cycle: sample sees the old coefficient.
      coef_we = 1'b1; coef_bank = 1'b1; coef_idx = 4'd0; coef_data = 12'sd512;
      in_valid = 1'b1; in_data = 8'sd10; bank_sel = 1'b1;
      cycle();
      coef_we = 1'b0;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== -8'sd10) begin
         failures++;
         $display("FAIL write_same_cycle valid=%b data=%0d, required 1/-10", out_valid, out_data);
      end
      bank_sel = 1'b0;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'sd10) begin
         failures++;
         $display("FAIL write_next_sample valid=%b data=%0d, required 1/10", out_valid, out_data);
      end
      in_valid = 1'b0;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'sd40 || out_sat !== 1'b0) begin
         failures++;
         $display("FAIL bank0_select valid=%b data=%0d sat=%b, required 1/40/0",
                  out_valid, out_data, out_sat);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'sd40) begin
         failures++;
         $display("FAIL hold_idle valid=%b data=%0d, required 0/40", out_valid, out_data);
      end
   endtask

   task automatic test_impulse();
      hist_clr = 1'b1;
      cycle();
      hist_clr = 1'b0;
      for (int k = 0; k < 16; k++) begin
         write_coef(1'b0, 4'(k), 12'(64 * k));
      end
      bank_sel = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         in_valid = (i < 16);
         in_data  = (i == 0) ? 8'sd8 : 8'sd0;
         cycle();
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i - 1) || out_sat !== 1'b0) begin
               failures++;
               $display("FAIL impulse[%0d] valid=%b data=%0d sat=%b, required 1/%0d/0",
                        i - 1, out_valid, out_data, out_sat, i - 1);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_gaps();
      bit                vflag [$];
      logic signed [7:0] ex [4];
      logic signed [7:0] last;
      logic              s1;
      logic              exp_ov;
      int                got;
      ex   = '{8'sd0, 8'sd1, 8'sd3, 8'sd6};
      last = 8'sd15;
      s1   = 1'b0;
      got  = 0;
      hist_clr = 1'b1;
      cycle();
      hist_clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 3)) vflag.push_back(1'b0);
         vflag.push_back(1'b1);
      end
      repeat (3) vflag.push_back(1'b0);
      for (int c = 0; c < vflag.size(); c++) begin
         in_valid = vflag[c];
         in_data  = 8'sd8;
         exp_ov   = s1;
         s1       = vflag[c];
         cycle();
         if (exp_ov) begin
            last = ex[got];
            got++;
         end
         checks++;
         if (out_valid !== exp_ov || out_data !== last) begin
            failures++;
            $display("FAIL gaps[cycle %0d] valid=%b data=%0d, required %b/%0d",
                     c, out_valid, out_data, exp_ov, last);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_clear();
      // History is 8,8,8,8 here; clear with a simultaneous sample drops it.
      hist_clr = 1'b1; in_valid = 1'b1; in_data = 8'sd8;
      cycle();
      hist_clr = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (out_valid !== 1'b0 || out_data !== 8'sd6) begin
            failures++;
            $display("FAIL clear_drop[%0d] valid=%b data=%0d, required 0/6", i, out_valid, out_data);
         end
      end
      for (int i = 0; i <= 2; i++) begin
         in_valid = (i < 2);
         in_data  = (i == 0) ? 8'sd8 : 8'sd0;
         cycle();
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i - 1)) begin
               failures++;
               $display("FAIL clear_hist[%0d] valid=%b data=%0d, required 1/%0d",
                        i - 1, out_valid, out_data, i - 1);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      in_valid = 1'b1; in_data = 8'sd8;
      repeat (3) cycle();
      #2;
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'sd0 || out_sat !== 1'b0) begin
         failures++;
         $display("FAIL reset_async valid=%b data=%0d sat=%b, required 0/0/0",
                  out_valid, out_data, out_sat);
      end
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flush[%0d] valid=%b, required 0", i, out_valid);
         end
      end
      for (int i = 0; i <= 4; i++) begin
         in_valid = (i < 4);
         in_data  = (i == 0) ? 8'sd8 : 8'sd0;
         cycle();
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'sd0 || out_sat !== 1'b0) begin
               failures++;
               $display("FAIL reset_coefs[%0d] valid=%b data=%0d sat=%b, required 1/0/0",
                        i - 1, out_valid, out_data, out_sat);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      bank_sel  = '0;
      coef_we   = 1'b0;
      coef_bank = '0;
      coef_idx  = '0;
      coef_data = '0;
      hist_clr  = 1'b0;
      test_reset();
      test_rounding();
      test_saturation();
      test_bank_timing();
      test_impulse();
      test_gaps();
      test_clear();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
